accel_tilt_filter: RTL and testbench

Conditions raw accelerometer samples into per-axis ball velocity steps. It sits between `AccelerometerCtl` (offset-binary `ACCEL_X_OUT`/`ACCEL_Y_OUT`, 256 = level) and `Ball`. At a fixed sample rate it runs a 4-tap moving average per axis, removes the 256 offset, applies a dead zone, scales and clamps the result, and presents signed velocities with a one-cycle update strobe.

---
 rtl/accel_tilt_filter_pkg.sv | 43 ++++
 rtl/accel_tilt_filter_moving_avg4.sv | 32 +++
 rtl/accel_tilt_filter.sv | 108 ++++++++++
 tb/tb_accel_tilt_filter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/accel_tilt_filter_pkg.sv
// Shared constants, FSM encoding and the dead-zone/scale/clamp helper for the
// accelerometer tilt filter.
package accel_tilt_filter_pkg;

  localparam int ACCEL_ZERO = 256;
  localparam int ACCEL_W    = 9;
  localparam int VEL_W      = 4;
  localparam int SUM_W      = 11;
  localparam int FILL_MAX   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SUM     = 2'd2,
    ST_SCALE   = 2'd3
  } state_e;

  // Magnitude is computed first and the sign applied last, so negative tilts
  // round toward zero exactly like positive ones.
  function automatic logic [VEL_W-1:0] scale_tilt(
    input logic [ACCEL_W-1:0] avg,
    input int                 deadzone,
    input int                 shift,
    input int                 vmax
  );
    logic [ACCEL_W:0]   tilt;
    logic [ACCEL_W:0]   mag;
    logic [ACCEL_W:0]   step;
    logic [VEL_W-1:0]   v;
    tilt = {1'b0, avg} - (ACCEL_W+1)'(ACCEL_ZERO);
    mag  = tilt[ACCEL_W] ? -tilt : tilt;
    step = mag >> shift;
    if (int'(mag) < deadzone) begin
      v = '0;
    end else if (int'(step) > vmax) begin
      v = VEL_W'(vmax);
    end else begin
      v = step[VEL_W-1:0];
    end
    return tilt[ACCEL_W] ? -v : v;
  endfunction

endpackage

// File: rtl/accel_tilt_filter_moving_avg4.sv
// Four-tap shift register with an 11-bit adder; avg is the truncated mean of
// the taps.
module moving_avg4
  import accel_tilt_filter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [ACCEL_W-1:0] din,
  output logic [ACCEL_W-1:0] avg
);

  logic [ACCEL_W-1:0] taps_q [FILL_MAX];
  logic [SUM_W-1:0]   sum;

  // NOTE: the tap array is only four words of flops, so it is reset like any
  // other register; a RAM-style array would be left unreset instead.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int i = 0; i < FILL_MAX; i++) taps_q[i] <= '0;
    end else if (shift_en) begin
      taps_q[0] <= din;
      for (int i = 1; i < FILL_MAX; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign sum = SUM_W'(taps_q[0]) + SUM_W'(taps_q[1])
             + SUM_W'(taps_q[2]) + SUM_W'(taps_q[3]);
  assign avg = sum[SUM_W-1:2];

endmodule

// File: rtl/accel_tilt_filter.sv
// Sample-rate divider, capture/sum/scale sequencer and velocity output
// registers for the per-axis tilt filter.
module accel_tilt_filter
  import accel_tilt_filter_pkg::*;
#(
  parameter int SAMPLE_DIV = 1_000_000,
  parameter int DEADZONE   = 8,
  parameter int SHIFT      = 4,
  parameter int VMAX       = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ACCEL_W-1:0] accel_x,
  input  logic [ACCEL_W-1:0] accel_y,
  output logic [VEL_W-1:0]   vel_x,
  output logic [VEL_W-1:0]   vel_y,
  output logic               vel_valid,
  output logic               filled
);

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         fill_q;
  logic [ACCEL_W-1:0] avg_x, avg_y;
  logic [ACCEL_W-1:0] avg_x_q, avg_y_q;
  logic               div_wrap;
  logic               capture_en;

  assign div_wrap   = (div_q == DIV_LAST);
  assign capture_en = enable && (state_q == ST_CAPTURE);

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (div_wrap) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SUM;
      ST_SUM:     state_d = ST_SCALE;
      ST_SCALE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  moving_avg4 u_avg_x (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .shift_en (capture_en),
    .din      (accel_x),
    .avg      (avg_x)
  );

  moving_avg4 u_avg_y (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .shift_en (capture_en),
    .din      (accel_y),
    .avg      (avg_y)
  );

  // Dropping enable behaves like reset for the whole datapath, discarding any
  // sample still travelling through SUM/SCALE.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      div_q     <= '0;
      fill_q    <= '0;
      avg_x_q   <= '0;
      avg_y_q   <= '0;
      vel_x     <= '0;
      vel_y     <= '0;
      vel_valid <= 1'b0;
      filled    <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (state_q == ST_IDLE) begin
        div_q <= div_wrap ? '0 : div_q + 1'b1;
      end
      if (state_q == ST_CAPTURE && fill_q != 3'(FILL_MAX)) begin
        fill_q <= fill_q + 1'b1;
      end
      if (state_q == ST_SUM) begin
        avg_x_q <= avg_x;
        avg_y_q <= avg_y;
      end
      if (state_q == ST_SCALE && fill_q == 3'(FILL_MAX)) begin
        vel_x     <= scale_tilt(avg_x_q, DEADZONE, SHIFT, VMAX);
        vel_y     <= scale_tilt(avg_y_q, DEADZONE, SHIFT, VMAX);
        vel_valid <= 1'b1;
        filled    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Self-checking bench for accel_tilt_filter: cycle-stepped reference model
// (sample queue + arithmetic) compared against the DUT on every cycle.
module tb_accel_tilt_filter;

  localparam int SAMPLE_DIV  = 8;
  localparam int PERIOD      = SAMPLE_DIV + 3;
  localparam int FIRST_CAP   = SAMPLE_DIV + 1;
  localparam int FIRST_PULSE = SAMPLE_DIV + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] accel_x, accel_y;
  logic [3:0] vel_x, vel_y;
  logic       vel_valid, filled;

  accel_tilt_filter #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .accel_x   (accel_x),
    .accel_y   (accel_y),
    .vel_x     (vel_x),
    .vel_y     (vel_y),
    .vel_valid (vel_valid),
    .filled    (filled)
  );

  always #5 clk = ~clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         edge_cnt   = 0;
  int         qx[$];
  int         qy[$];
  logic [3:0] exp_vx     = '0;
  logic [3:0] exp_vy     = '0;
  logic       exp_valid  = 1'b0;
  logic       exp_filled = 1'b0;
  int         want_x     = 256;
  int         want_y     = 256;

  int         step_exp [5] = '{1, 2, 3, 4, 4};
  int         tbl_in   [6] = '{263, 249, 272, 240, 511, 0};
  logic [3:0] tbl_exp  [6] = '{4'd0, 4'd0, 4'd1, 4'b1111, 4'd7, 4'b1001};

  // Velocity from four raw samples: mean, remove 256, dead zone 8, /16, clamp 7.
  function automatic int ref_vel(input int a, input int b, input int c, input int d);
    int avg, tilt, mag, v;
    avg  = (a + b + c + d) / 4;
    tilt = avg - 256;
    mag  = (tilt < 0) ? -tilt : tilt;
    if (mag < 8) return 0;
    v = mag / 16;
    if (v > 7) v = 7;
    return (tilt < 0) ? -v : v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge,
  // then drive the next inputs (target value only where a capture is due).
  task automatic tick();
    @(posedge clk);
    if (reset !== 1'b1 || enable !== 1'b1) begin
      edge_cnt   = 0;
      qx.delete();
      qy.delete();
      exp_vx     = '0;
      exp_vy     = '0;
      exp_valid  = 1'b0;
      exp_filled = 1'b0;
    end else begin
      edge_cnt++;
      exp_valid = 1'b0;
      if (edge_cnt >= FIRST_CAP && (edge_cnt - FIRST_CAP) % PERIOD == 0) begin
        qx.push_back(int'(accel_x));
        qy.push_back(int'(accel_y));
        if (qx.size() > 4) void'(qx.pop_front());
        if (qy.size() > 4) void'(qy.pop_front());
      end
      if (edge_cnt >= FIRST_PULSE && (edge_cnt - FIRST_PULSE) % PERIOD == 0
          && qx.size() == 4) begin
        exp_vx     = 4'(ref_vel(qx[0], qx[1], qx[2], qx[3]));
        exp_vy     = 4'(ref_vel(qy[0], qy[1], qy[2], qy[3]));
        exp_valid  = 1'b1;
        exp_filled = 1'b1;
      end
    end
    @(negedge clk);
    check("vel_valid", 8'(vel_valid), 8'(exp_valid));
    check("filled",    8'(filled),    8'(exp_filled));
    check("vel_x",     8'(vel_x),     8'(exp_vx));
    check("vel_y",     8'(vel_y),     8'(exp_vy));
    if ((edge_cnt + 1 - FIRST_CAP) >= 0 && (edge_cnt + 1 - FIRST_CAP) % PERIOD == 0) begin
      accel_x = 9'(want_x);
      accel_y = 9'(want_y);
    end else begin
      accel_x = 9'($urandom_range(0, 511));
      accel_y = 9'($urandom_range(0, 511));
    end
  endtask

  task automatic run_samples(input int n);
    repeat (n * PERIOD) tick();
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b1;
    accel_x = 9'($urandom_range(0, 511));
    accel_y = 9'($urandom_range(0, 511));

    // Reset held for five clocks with random inputs.
    repeat (5) tick();
    check("rst_vel_x", 8'(vel_x), 8'd0);
    check("rst_valid", 8'(vel_valid), 8'd0);

    // Constant tilt; first pulse on the 4th sample.
    reset  = 1'b1;
    want_x = 320;
    want_y = 256;
    run_samples(3);
    check("warmup_filled", 8'(filled), 8'd0);
    run_samples(1);
    check("const_valid", 8'(vel_valid), 8'd1);
    check("const_vel_x", 8'(vel_x), 8'd4);
    check("const_vel_y", 8'(vel_y), 8'd0);
    check("const_filled", 8'(filled), 8'd1);
    run_samples(2);

    // Step response from level to 320.
    want_x = 256;
    run_samples(4);
    check("step_base", 8'(vel_x), 8'd0);
    want_x = 320;
    for (int i = 0; i < 5; i++) begin
      run_samples(1);
      check($sformatf("step_%0d", i), 8'(vel_x), 8'(4'(step_exp[i])));
    end

    // Dead zone, sign symmetry and clamp.
    for (int i = 0; i < 6; i++) begin
      want_x = tbl_in[i];
      want_y = int'($urandom_range(0, 511));
      run_samples(4);
      check($sformatf("table_%0d", tbl_in[i]), 8'(vel_x), 8'(tbl_exp[i]));
    end

    // Drop enable while the sample is in SUM.
    want_x = 320;
    want_y = 256;
    run_samples(4);
    repeat (FIRST_CAP) tick();
    enable = 1'b0;
    tick();
    check("drop_vel_x", 8'(vel_x), 8'd0);
    check("drop_filled", 8'(filled), 8'd0);
    check("drop_valid", 8'(vel_valid), 8'd0);
    repeat (3) tick();
    enable = 1'b1;
    run_samples(3);
    check("reen_no_pulse", 8'(vel_valid), 8'd0);
    run_samples(1);
    check("reen_valid", 8'(vel_valid), 8'd1);
    check("reen_vel_x", 8'(vel_x), 8'd4);

    // Random samples on both axes.
    repeat (20) begin
      want_x = int'($urandom_range(0, 511));
      want_y = int'($urandom_range(0, 511));
      run_samples(1);
    end

    // Reset in the middle of a sample period.
    repeat (10) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("midrst_filled", 8'(filled), 8'd0);
    reset  = 1'b1;
    want_x = 0;
    want_y = 511;
    run_samples(4);
    check("midrst_vel_x", 8'(vel_x), 8'b1001);
    check("midrst_vel_y", 8'(vel_y), 8'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
